pong_game_core: RTL and testbench

- Pixel-source stage of the HDMI pong design.
- Consumes the raw pixel counters and sync/DE flags from the 640x480 timing generator, plus the rotary-encoder quadrature inputs.
- Runs the paddle, ball and serve/miss game logic.
- Emits registered 8-bit R/G/B, with DE/hsync/vsync realigned, directly into the three TMDS encoders.

---
 rtl/pong_pkg.sv | 16 +
 rtl/pong_game_core_quad.sv | 41 ++++
 rtl/pong_game_core.sv | 188 ++++++++++++++++++
 tb/tb_pong_game_core.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared game-state encoding, colours and start positions for the pong pixel source.
package pong_pkg;

  typedef enum logic [1:0] {SERVE, PLAY, MISS} game_state_t;

  localparam logic [23:0] WHITE     = 24'hFF_FFFF;
  localparam logic [23:0] BALL_MISS = 24'hFF_0000;
  localparam logic [23:0] BG_CHECK  = 24'h20_2020;
  // Red channel forced onto the background during the miss flash.
  localparam logic [7:0]  BG_MISS   = 8'h40;

  localparam logic [9:0] SERVE_X      = 10'd312;
  localparam logic [8:0] SERVE_Y      = 9'd240;
  localparam logic [8:0] PADDLE_RESET = 9'd192;

endpackage

// File: rtl/pong_game_core_quad.sv
// Rotary-encoder front end: synchronises the quadrature phases and tracks a clamped paddle position.
module quad_decoder
  import pong_pkg::*;
(
  input  logic       pixclk,
  input  logic       rst,
  input  logic       quadA,
  input  logic       quadB,
  output logic [8:0] position
);

  logic [2:0] sync_a;
  logic [2:0] sync_b;
  logic       step;
  logic       dir;

  always_ff @(posedge pixclk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[1:0], quadA};
      sync_b <= {sync_b[1:0], quadB};
    end
  end

  assign step = sync_a[2] ^ sync_a[1] ^ sync_b[2] ^ sync_b[1];
  assign dir  = sync_a[2] ^ sync_b[1];

  always_ff @(posedge pixclk) begin
    if (rst) begin
      position <= PADDLE_RESET;
    end else if (step) begin
      if (dir && position != '1)
        position <= position + 9'd1;
      else if (!dir && position != '0)
        position <= position - 9'd1;
    end
  end

endmodule

// File: rtl/pong_game_core.sv
// Pong pixel source: paddle/ball/serve-miss game logic and registered RGB with realigned syncs.
module pong_game_core
  import pong_pkg::*;
#(
  parameter int unsigned BALL_SIZE    = 16,
  parameter int unsigned PADDLE_WIDTH = 112,
  parameter int unsigned PADDLE_ROW   = 27,
  parameter int unsigned MISS_Y       = 464,
  parameter int unsigned TICK_LINE    = 500,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned MISS_FRAMES  = 30
) (
  input  logic       pixclk,
  input  logic       rst,
  input  logic       quadA,
  input  logic       quadB,
  input  logic [9:0] counter_x,
  input  logic [9:0] counter_y,
  input  logic       draw_area_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       de_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [3:0] misses
);

  localparam int unsigned CNT_W =
    $clog2((SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES);

  logic [8:0]  paddle_pos;
  game_state_t state, state_n;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_n;
  logic [9:0]  ball_x, ball_x_n;
  logic [8:0]  ball_y, ball_y_n;
  logic        dir_x, dir_x_n, dir_y, dir_y_n;
  logic [3:0]  misses_n;
  logic        hit_x1, hit_x2, hit_y1, hit_y2;
  logic        border, paddle, ball, bouncer, tick;
  logic [10:0] cx, cy, bx, by, px;
  logic [23:0] pixel;

  quad_decoder u_quad (
    .pixclk   (pixclk),
    .rst      (rst),
    .quadA    (quadA),
    .quadB    (quadB),
    .position (paddle_pos)
  );

  // Widened copies so probe and object sums never truncate.
  assign cx = {1'b0, counter_x};
  assign cy = {1'b0, counter_y};
  assign bx = 11'(ball_x);
  assign by = 11'(ball_y);
  assign px = 11'(paddle_pos);

  assign border  = counter_x[9:3] == 7'd0 || counter_x[9:3] == 7'd79 || counter_y[8:3] == 6'd0;
  assign paddle  = cx >= px + 11'd8 && cx <= px + 11'(8 + PADDLE_WIDTH) &&
                   counter_y[8:4] == 5'(PADDLE_ROW);
  assign ball    = cx >= bx && cx < bx + 11'(BALL_SIZE) && cy >= by && cy < by + 11'(BALL_SIZE);
  assign bouncer = border | paddle;
  assign tick    = counter_y == 10'(TICK_LINE) && counter_x == '0;

  always_ff @(posedge pixclk) begin
    if (rst || tick) begin
      hit_x1 <= 1'b0;
      hit_x2 <= 1'b0;
      hit_y1 <= 1'b0;
      hit_y2 <= 1'b0;
    end else if (bouncer) begin
      if (cx == bx && cy == by + 11'(BALL_SIZE / 2))                       hit_x1 <= 1'b1;
      if (cx == bx + 11'(BALL_SIZE) && cy == by + 11'(BALL_SIZE / 2))      hit_x2 <= 1'b1;
      if (cx == bx + 11'(BALL_SIZE / 2) && cy == by)                       hit_y1 <= 1'b1;
      if (cx == bx + 11'(BALL_SIZE / 2) && cy == by + 11'(BALL_SIZE))      hit_y2 <= 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    ball_x_n    = ball_x;
    ball_y_n    = ball_y;
    dir_x_n     = dir_x;
    dir_y_n     = dir_y;
    misses_n    = misses;
    if (tick) begin
      unique case (state)
        SERVE: begin
          ball_x_n = SERVE_X;
          ball_y_n = SERVE_Y;
          dir_x_n  = 1'b0;
          dir_y_n  = 1'b1;
          if (frame_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
            frame_cnt_n = '0;
            state_n     = PLAY;
          end else begin
            frame_cnt_n = frame_cnt + CNT_W'(1);
          end
        end
        PLAY: begin
          if (ball_y >= 9'(MISS_Y)) begin
            if (misses != '1) misses_n = misses + 4'd1;
            frame_cnt_n = '0;
            state_n     = MISS;
          end else begin
            // Move with the pre-tick direction, then apply the bounce.
            if (!(hit_x1 && hit_x2)) begin
              ball_x_n = dir_x ? ball_x - 10'd1 : ball_x + 10'd1;
              if (hit_x2)      dir_x_n = 1'b1;
              else if (hit_x1) dir_x_n = 1'b0;
            end
            if (!(hit_y1 && hit_y2)) begin
              ball_y_n = dir_y ? ball_y - 9'd1 : ball_y + 9'd1;
              if (hit_y2)      dir_y_n = 1'b1;
              else if (hit_y1) dir_y_n = 1'b0;
            end
          end
        end
        MISS: begin
          if (frame_cnt == CNT_W'(MISS_FRAMES - 1)) begin
            frame_cnt_n = '0;
            state_n     = SERVE;
            ball_x_n    = SERVE_X;
            ball_y_n    = SERVE_Y;
            dir_x_n     = 1'b0;
            dir_y_n     = 1'b1;
          end else begin
            frame_cnt_n = frame_cnt + CNT_W'(1);
          end
        end
        default: state_n = SERVE;
      endcase
    end
  end

  always_ff @(posedge pixclk) begin
    if (rst) begin
      state     <= SERVE;
      frame_cnt <= '0;
      ball_x    <= SERVE_X;
      ball_y    <= SERVE_Y;
      dir_x     <= 1'b0;
      dir_y     <= 1'b1;
      misses    <= '0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_cnt_n;
      ball_x    <= ball_x_n;
      ball_y    <= ball_y_n;
      dir_x     <= dir_x_n;
      dir_y     <= dir_y_n;
      misses    <= misses_n;
    end
  end

  always_comb begin
    pixel = '0;
    if (!draw_area_in) begin
      pixel = '0;
    end else if (bouncer) begin
      pixel = WHITE;
    end else if (ball) begin
      pixel = (state == MISS) ? BALL_MISS : WHITE;
    end else begin
      pixel = (counter_x[3] ^ counter_y[3]) ? BG_CHECK : '0;
      if (state == MISS) pixel[23:16] = BG_MISS;
    end
  end

  always_ff @(posedge pixclk) begin
    if (rst) begin
      {red, green, blue} <= '0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      {red, green, blue} <= pixel;
      de_out    <= draw_area_in;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
    end
  end

endmodule

// File: tb/tb_pong_game_core.sv
// Bench for pong_game_core: drives counters directly and checks pixels against a frame-level game model.
module tb_pong_game_core;

  logic       pixclk = 1'b0;
  logic       rst;
  logic       quadA, quadB;
  logic [9:0] counter_x, counter_y;
  logic       draw_area_in, hsync_in, vsync_in;
  logic [7:0] red, green, blue;
  logic       de_out, hsync_out, vsync_out;
  logic [3:0] misses;

  int total = 0;
  int bad   = 0;

  pong_game_core dut (
    .pixclk       (pixclk),
    .rst          (rst),
    .quadA        (quadA),
    .quadB        (quadB),
    .counter_x    (counter_x),
    .counter_y    (counter_y),
    .draw_area_in (draw_area_in),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .de_out       (de_out),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .misses       (misses)
  );

  always #20 pixclk = ~pixclk;

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  // Frame-level game model: velocities instead of direction bits.
  typedef enum int {M_SERVE, M_PLAY, M_MISS} mstate_t;
  mstate_t m_state;
  int m_bx, m_by, m_vx, m_vy, m_cnt, m_misses, m_pad;
  int q_phase = 0;

  task automatic m_reset();
    m_state = M_SERVE; m_bx = 312; m_by = 240; m_vx = 1; m_vy = -1;
    m_cnt = 0; m_misses = 0; m_pad = 192;
  endtask

  function automatic bit m_bouncer(input int x, input int y);
    bit brd, pad;
    brd = (x / 8 == 0) || (x / 8 == 79) || ((y % 512) / 8 == 0);
    pad = (x >= m_pad + 8) && (x <= m_pad + 8 + 112) && ((y % 512) / 16 == 27);
    return brd || pad;
  endfunction

  function automatic logic [23:0] m_rgb(input int x, input int y, input bit de);
    logic [23:0] c;
    if (!de) return 24'h0;
    if (m_bouncer(x, y)) return 24'hFFFFFF;
    if (x >= m_bx && x < m_bx + 16 && y >= m_by && y < m_by + 16)
      return (m_state == M_MISS) ? 24'hFF0000 : 24'hFFFFFF;
    c = (((x / 8) + (y / 8)) % 2 == 1) ? 24'h202020 : 24'h000000;
    if (m_state == M_MISS) c[23:16] = 8'h40;
    return c;
  endfunction

  task automatic m_tick();
    bit x1, x2, y1, y2;
    x1 = m_bouncer(m_bx, m_by + 8);
    x2 = m_bouncer(m_bx + 16, m_by + 8);
    y1 = m_bouncer(m_bx + 8, m_by);
    y2 = m_bouncer(m_bx + 8, m_by + 16);
    case (m_state)
      M_SERVE: begin
        m_bx = 312; m_by = 240; m_vx = 1; m_vy = -1;
        m_cnt++;
        if (m_cnt == 60) begin m_cnt = 0; m_state = M_PLAY; end
      end
      M_PLAY: begin
        if (m_by >= 464) begin
          if (m_misses < 15) m_misses++;
          m_cnt = 0; m_state = M_MISS;
        end else begin
          if (!(x1 && x2)) begin
            m_bx += m_vx;
            if (x2) m_vx = -1; else if (x1) m_vx = 1;
          end
          if (!(y1 && y2)) begin
            m_by += m_vy;
            if (y2) m_vy = -1; else if (y1) m_vy = 1;
          end
        end
      end
      default: begin
        m_cnt++;
        if (m_cnt == 30) begin
          m_cnt = 0; m_state = M_SERVE;
          m_bx = 312; m_by = 240; m_vx = 1; m_vy = -1;
        end
      end
    endcase
  endtask

  task automatic cyc(input int x, input int y, input bit de, input bit hs, input bit vs);
    counter_x = 10'(x); counter_y = 10'(y);
    draw_area_in = de; hsync_in = hs; vsync_in = vs;
    @(posedge pixclk); #1;
  endtask

  task automatic pix(input int x, input int y, output logic [23:0] got);
    cyc(x, y, 1'b1, 1'b0, 1'b0);
    got = {red, green, blue};
  endtask

  function automatic void ball_pt(input int k, output int x, output int y);
    case (k)
      0:       begin x = m_bx;      y = m_by;      end
      1:       begin x = m_bx - 1;  y = m_by;      end
      2:       begin x = m_bx + 15; y = m_by + 15; end
      default: begin x = m_bx + 16; y = m_by + 15; end
    endcase
  endfunction

  // One game frame: visit the four collision probe points, then the tick.
  task automatic do_frame();
    cyc(m_bx, m_by + 8, 1'b0, 1'b0, 1'b0);
    cyc(m_bx + 16, m_by + 8, 1'b0, 1'b0, 1'b0);
    cyc(m_bx + 8, m_by, 1'b0, 1'b0, 1'b0);
    cyc(m_bx + 8, m_by + 16, 1'b0, 1'b0, 1'b0);
    cyc(0, 500, 1'b0, 1'b0, 1'b1);
    m_tick();
    cyc(700, 510, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic qstep(input bit fwd);
    q_phase = fwd ? (q_phase + 1) % 4 : (q_phase + 3) % 4;
    quadA = (q_phase == 2 || q_phase == 3);
    quadB = (q_phase == 1 || q_phase == 2);
    if (fwd) begin
      if (m_pad < 511) m_pad++;
    end else if (m_pad > 0) begin
      m_pad--;
    end
    repeat (4 + $urandom_range(0, 2)) cyc(700, 510, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [23:0] got;
    int x, y;
    rst = 1'b1; quadA = 1'b0; quadB = 1'b0;
    cyc(300, 100, 1'b1, 1'b1, 1'b1);
    total++;
    if ({red, green, blue, de_out, hsync_out, vsync_out, misses} !== 31'h0) begin
      bad++;
      $display("FAIL reset_outputs got rgb=%h de=%b hs=%b vs=%b misses=%0d want all zero",
               {red, green, blue}, de_out, hsync_out, vsync_out, misses);
    end
    repeat (3) cyc(300, 100, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    m_reset();
    for (int k = 0; k < 4; k++) begin
      ball_pt(k, x, y);
      pix(x, y, got);
      total++;
      if (got !== m_rgb(x, y, 1'b1)) begin
        bad++;
        $display("FAIL reset_ball (%0d,%0d) got=%h want=%h", x, y, got, m_rgb(x, y, 1'b1));
      end
    end
    for (int k = 0; k < 4; k++) begin
      x = (k < 2) ? 199 + k : 311 + k;
      pix(x, 440, got);
      total++;
      if (got !== m_rgb(x, 440, 1'b1)) begin
        bad++;
        $display("FAIL reset_paddle x=%0d got=%h want=%h", x, got, m_rgb(x, 440, 1'b1));
      end
    end
  endtask

  task automatic test_sync_align();
    int x, y;
    bit de, hs, vs;
    for (int i = 0; i < 48; i++) begin
      x = $urandom_range(0, 799);
      y = $urandom_range(0, 524);
      if (y == 500) y = 501;
      de = 1'($urandom); hs = 1'($urandom); vs = 1'($urandom);
      cyc(x, y, de, hs, vs);
      total++;
      if ({de_out, hsync_out, vsync_out, red, green, blue} !== {de, hs, vs, m_rgb(x, y, de)}) begin
        bad++;
        $display("FAIL sync_align (%0d,%0d) got de/hs/vs=%b%b%b rgb=%h want %b%b%b %h",
                 x, y, de_out, hsync_out, vsync_out, {red, green, blue}, de, hs, vs, m_rgb(x, y, de));
      end
    end
  endtask

  task automatic test_quad_clamp();
    logic [23:0] got;
    int x;
    for (int pass = 0; pass < 2; pass++) begin
      for (int s = 1; s <= ((pass == 0) ? 520 : 600); s++) begin
        qstep(pass == 0);
        if (s % 130 == 0 || s == 520 || s == 600) begin
          for (int k = 0; k < 4; k++) begin
            x = m_pad + ((k == 0) ? 7 : (k == 1) ? 8 : (k == 2) ? 120 : 121);
            pix(x, 440, got);
            total++;
            if (got !== m_rgb(x, 440, 1'b1)) begin
              bad++;
              $display("FAIL quad_paddle pos=%0d x=%0d got=%h want=%h", m_pad, x, got, m_rgb(x, 440, 1'b1));
            end
          end
        end
      end
    end
  endtask

  task automatic test_serve();
    logic [23:0] got;
    int x, y;
    for (int f = 1; f <= 61; f++) begin
      do_frame();
      if (f >= 59) begin
        for (int k = 0; k < 4; k++) begin
          ball_pt(k, x, y);
          pix(x, y, got);
          total++;
          if (got !== m_rgb(x, y, 1'b1)) begin
            bad++;
            $display("FAIL serve_ball frame=%0d (%0d,%0d) got=%h want=%h", f, x, y, got, m_rgb(x, y, 1'b1));
          end
        end
      end
    end
    pix(313, 239, got);
    total++;
    if (got !== 24'hFFFFFF) begin
      bad++;
      $display("FAIL first_move got=%h want=ffffff at (313,239)", got);
    end
  endtask

  task automatic test_bounce_top();
    logic [23:0] got;
    int x, y, after;
    after = -1;
    for (int f = 0; f < 300 && after < 3; f++) begin
      do_frame();
      if (after >= 0 || m_vy > 0) after++;
      if (f % 16 == 0 || after >= 0) begin
        for (int k = 0; k < 4; k++) begin
          ball_pt(k, x, y);
          pix(x, y, got);
          total++;
          if (got !== m_rgb(x, y, 1'b1)) begin
            bad++;
            $display("FAIL bounce_ball (%0d,%0d) got=%h want=%h", x, y, got, m_rgb(x, y, 1'b1));
          end
        end
      end
    end
    total++;
    if (after < 3) begin
      bad++;
      $display("FAIL bounce_timeout got after=%0d want 3", after);
    end
  endtask

  task automatic test_miss();
    logic [23:0] got;
    int x, y, f;
    f = 0;
    while (m_state != M_MISS && f < 800) begin
      do_frame();
      f++;
      if (f % 32 == 0) begin
        ball_pt(0, x, y);
        pix(x, y, got);
        total++;
        if (got !== m_rgb(x, y, 1'b1)) begin
          bad++;
          $display("FAIL descend_ball (%0d,%0d) got=%h want=%h", x, y, got, m_rgb(x, y, 1'b1));
        end
      end
    end
    total++;
    if (m_state != M_MISS || misses !== 4'(m_misses)) begin
      bad++;
      $display("FAIL miss_count got=%0d want=%0d (model reached miss=%0d)", misses, m_misses, m_state == M_MISS);
    end
    for (int fr = 0; fr <= 30; fr++) begin
      for (int k = 0; k < 5; k++) begin
        if (k < 4) ball_pt(k, x, y);
        else begin x = 200; y = 300; end
        pix(x, y, got);
        total++;
        if (got !== m_rgb(x, y, 1'b1)) begin
          bad++;
          $display("FAIL miss_flash frame=%0d (%0d,%0d) got=%h want=%h", fr, x, y, got, m_rgb(x, y, 1'b1));
        end
      end
      if (fr < 30) do_frame();
    end
    total++;
    if (misses !== 4'(m_misses)) begin
      bad++;
      $display("FAIL miss_hold got=%0d want=%0d", misses, m_misses);
    end
  endtask

  task automatic test_midgame_reset();
    logic [23:0] got;
    int x, y;
    repeat (70) do_frame();
    rst = 1'b1;
    cyc(300, 100, 1'b1, 1'b1, 1'b1);
    total++;
    if ({red, green, blue, de_out, hsync_out, vsync_out, misses} !== 31'h0) begin
      bad++;
      $display("FAIL midgame_reset got rgb=%h de=%b misses=%0d want all zero",
               {red, green, blue}, de_out, misses);
    end
    rst = 1'b0;
    m_reset();
    for (int k = 0; k < 4; k++) begin
      ball_pt(k, x, y);
      pix(x, y, got);
      total++;
      if (got !== m_rgb(x, y, 1'b1)) begin
        bad++;
        $display("FAIL restart_ball (%0d,%0d) got=%h want=%h", x, y, got, m_rgb(x, y, 1'b1));
      end
    end
    pix(200, 440, got);
    total++;
    if (got !== 24'hFFFFFF) begin
      bad++;
      $display("FAIL restart_paddle got=%h want=ffffff at (200,440)", got);
    end
  endtask

  initial begin
    test_reset();
    test_sync_align();
    test_quad_clamp();
    test_serve();
    test_bounce_top();
    test_miss();
    test_midgame_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
